// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path and the ALU decoder.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True on the cycle whose closing edge retires an instruction.
    function automatic logic retires(input state_e s, input logic mem_ready);
        return (s inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP}) ||
               (s == S_MEMWR && mem_ready);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, mux selects and the ALU decoder's alu_op.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             mem_write,
    output logic             reg_write,
    output logic             iord,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_reg;
    state_e           state_next;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retires(state_reg, mem_ready))
                count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_count = count_reg;

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore outputs; only FETCH (mem_ready) and DECODE (op) look at inputs.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state_reg)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                illegal_op = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle output
// trace from the opcode's phase list, then replayed against two DUT widths.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_ready;
    logic [5:0] op;

    logic        ir_write, pc_write, branch, mem_write, reg_write, iord;
    logic        reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_src, alu_op;
    logic [31:0] instr_count;

    logic        s_ir_write, s_pc_write, s_branch, s_mem_write, s_reg_write, s_iord;
    logic        s_reg_dst, s_mem_to_reg, s_alu_src_a, s_illegal_op;
    logic [1:0]  s_alu_src_b, s_pc_src, s_alu_op;
    logic [2:0]  s_count;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .mem_write(mem_write), .reg_write(reg_write), .iord(iord),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    // Narrow counter instance so wrap-around is reached in a short run.
    multicycle_control #(.CNT_W(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .ir_write(s_ir_write), .pc_write(s_pc_write), .branch(s_branch),
        .mem_write(s_mem_write), .reg_write(s_reg_write), .iord(s_iord),
        .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg), .alu_src_a(s_alu_src_a),
        .alu_src_b(s_alu_src_b), .pc_src(s_pc_src), .alu_op(s_alu_op),
        .illegal_op(s_illegal_op), .instr_count(s_count)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {ir_write, pc_write, branch, mem_write, reg_write, iord, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op};
    wire [15:0] s_obs = {s_ir_write, s_pc_write, s_branch, s_mem_write, s_reg_write, s_iord,
                         s_reg_dst, s_mem_to_reg, s_alu_src_a, s_alu_src_b, s_pc_src,
                         s_alu_op, s_illegal_op};

    int          checks = 0;
    int          failures = 0;
    logic [31:0] cnt_m;

    typedef struct {
        logic        mr;
        bit          use_op;
        logic [15:0] ov;
        string       name;
    } step_t;

    step_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ov(input logic ir, input logic pcw, input logic br,
                                       input logic mw, input logic rw, input logic io,
                                       input logic rd, input logic m2r, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [1:0] aop, input logic ill);
        return {ir, pcw, br, mw, rw, io, rd, m2r, asa, asb, pcs, aop, ill};
    endfunction

    function automatic logic [15:0] fetch_vec(input logic mr);
        return ov(mr, mr, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
    endfunction

    task automatic push(input string name, input logic mr, input bit use_op, input logic [15:0] v);
        step_t s;
        s.name = name; s.mr = mr; s.use_op = use_op; s.ov = v;
        q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle trace; returns whether it retires.
    task automatic build(input logic [5:0] iop, input int nf, input int nm, output bit retire);
        bit legal;
        q.delete();
        legal = (iop == 6'b000000) || (iop == 6'b100011) || (iop == 6'b101011) ||
                (iop == 6'b000100) || (iop == 6'b001000) || (iop == 6'b000010);
        for (int i = 0; i < nf; i++) push("fetch_wait", 1'b0, 0, fetch_vec(1'b0));
        push("fetch", 1'b1, 0, fetch_vec(1'b1));
        push("decode", 1'($urandom), 1, ov(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legal));
        retire = legal;
        case (iop)
            6'b100011, 6'b101011: begin
                push("memadr", 1'($urandom), 1, ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                if (iop == 6'b100011) begin
                    for (int i = 0; i < nm; i++) push("memrd_wait", 1'b0, 0, ov(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0));
                    push("memrd", 1'b1, 0, ov(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0));
                    push("memwb", 1'($urandom), 0, ov(0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,0));
                end else begin
                    for (int i = 0; i < nm; i++) push("memwr_wait", 1'b0, 0, ov(0,0,0,1,0,1,0,0,0,2'b00,2'b00,2'b00,0));
                    push("memwr", 1'b1, 0, ov(0,0,0,1,0,1,0,0,0,2'b00,2'b00,2'b00,0));
                end
            end
            6'b000000: begin
                push("execute", 1'($urandom), 0, ov(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0));
                push("aluwb", 1'($urandom), 0, ov(0,0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,0));
            end
            6'b000100: push("branch", 1'($urandom), 0, ov(0,0,1,0,0,0,0,0,1,2'b00,2'b01,2'b01,0));
            6'b001000: begin
                push("addiex", 1'($urandom), 0, ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0));
                push("addiwb", 1'($urandom), 0, ov(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0));
            end
            6'b000010: push("jump", 1'($urandom), 0, ov(0,1,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0));
            default: ;
        endcase
    endtask

    task automatic do_step(input step_t s, input logic [5:0] iop);
        mem_ready = s.mr;
        op = s.use_op ? iop : 6'($urandom);
        #3;
        check({s.name, " out"}, {16'h0, obs}, {16'h0, s.ov});
        check({s.name, " small_out"}, {16'h0, s_obs}, {16'h0, s.ov});
        check({s.name, " count"}, instr_count, cnt_m);
        check({s.name, " small_count"}, {29'h0, s_count}, {29'h0, cnt_m[2:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] iop, input int nf, input int nm);
        bit ret;
        int n;
        build(iop, nf, nm, ret);
        n = q.size();
        foreach (q[i]) do_step(q[i], iop);
        if (ret) cnt_m = cnt_m + 1;
        $display("instr op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d count=%0d",
                 iop, nf, nm, n, cnt_m);
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] rop;
        bit         ret;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        cnt_m = 0;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        op = 6'b0;
        #12;
        check("reset out", {16'h0, obs}, {16'h0, fetch_vec(1'b0)});
        check("reset count", instr_count, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(6'b100011, 3, 0);   // lw after 3 fetch stalls
        run_instr(6'b101011, 0, 2);   // sw with 2 memory stalls
        run_instr(6'b000000, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);   // illegal
        run_instr(6'b001000, 0, 0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) rop = 6'($urandom);
            else rop = legal_ops[$urandom_range(0, 5)];
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset dropped while stalled in the load's memory read.
        build(6'b100011, 0, 3, ret);
        for (int i = 0; i < 4; i++) do_step(q[i], 6'b100011);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        cnt_m = 0;
        check("midreset out", {16'h0, obs}, {16'h0, fetch_vec(1'b0)});
        check("midreset count", instr_count, 32'h0);
        check("midreset small_count", {29'h0, s_count}, 32'h0);
        $display("instr op=100011 reset during memrd count=%0d", cnt_m);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(6'b000000, 1, 0);
        run_instr(6'b100011, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
